vga_digit_rx: RTL and testbench
===============================

# vga_digit_rx

Receive-side companion to the VGA seven-segment digit generator. It samples an incoming 1024x768 VGA stream (`hs`, `vs`, 4:4:4 RGB) and checks the sync timing against the nominal raster until it locks. Once locked, it reads the seven segment regions of the displayed glyph once per frame and decodes them back into the 4-bit hex value. It sits on the loopback/self-test path and is clocked by the same pixel clock as the generator.

## Interface
- `H_TOTAL`, 1344, pixel clocks per line.
- `V_TOTAL`, 806, lines per frame.
- `LOCK_FRAMES`, 2, consecutive good frames required to lock (range 1..7).
- `clk_vga`  in  1  pixel clock; only clock.
- `rstn`  in  1  reset, synchronous and active-low.
- `hs`  in  1  horizontal sync, active-low pulse.
- `vs`  in  1  vertical sync, active-low pulse.
- `r`, `g`, `b`  in  4 each  pixel colour.
- `num`  out  4  last decoded digit.
- `num_valid`  out  1  one-cycle pulse when `num` is updated.
- `locked`  out  1  high while the sync timing is locked.
- `seg`  out  7  raw segment pattern sampled in the last evaluated frame; bit i is segment i.
- `frame_err`  out  1  one-cycle pulse when lock is lost.
- `pattern_err`  out  1  one-cycle pulse when a locked frame has an illegal pixel or an unknown pattern.

## Operation
- **Edge detect.** Registers `hs_d` and `vs_d` hold the previous sample; both reset to 1.
  - hs fall means `hs_d`=1 and `hs`=0.
  - vs fall means `vs_d`=1 and `vs`=0.
- **Position counters.** `h_pos` and `v_pos` are 11 bits each and saturate at 2047.
  - On every hs fall, `h_pos` is set to 0.
  - On a vs fall, `v_pos` is set to 0. Otherwise `v_pos` increments on each hs fall.
  - On all other cycles, `h_pos` increments.
  - The pixel sampled when `h_pos`=x and `v_pos`=y is raster pixel (x, y).
- **Line check.** At each hs fall after the first hs fall since SEARCH was entered, the line is good if `h_pos`+1 == `H_TOTAL`.
- **Frame check.** At each vs fall after the first, the frame is good if `v_pos`+1 == `V_TOTAL`, every line in it was good, and this vs fall coincides with an hs fall. A vs fall without a coincident hs fall is bad.
- **Lock state machine.**
  - SEARCH → CHECK on the first vs fall; clear `good_cnt`.
  - CHECK: on a good frame, `good_cnt`++. When it reaches `LOCK_FRAMES`, go to LOCKED. Any bad line or bad frame → SEARCH.
  - LOCKED: any bad line or bad frame → SEARCH, with a `frame_err` pulse.
  - `locked` = (state == LOCKED).
- **Sampling.** A pixel is lit when `r`=F, `g`=9, `b`=C. It is dark when `r`=`g`=`b`=0.
  - Any other colour at a sample point sets the frame's `pix_bad` flag.
  - Sample points, for segments 0..6: (800,100), (650,250), (950,250), (800,400), (650,550), (950,550), (800,700).
  - A 7-bit shadow register and `pix_bad` collect the samples and clear at each vs fall.
- **Evaluation** happens at the vs fall that ends a frame, and only if the whole frame was spent in LOCKED and the frame is good.
  - `seg` is loaded from the shadow register.
  - If `pix_bad` is set, or the pattern is not in the code table: pulse `pattern_err` and hold `num`.
  - Otherwise: load `num` with the decoded value and pulse `num_valid`.
- **Code table** (value: pattern, as hex):
  - 0: 77, 1: 24, 2: 5D, 3: 6D
  - 4: 2E, 5: 6B, 6: 7B, 7: 25
  - 8: 7F, 9: 6F, A: 3F, B: 7A
  - C: 53, D: 7C, E: 5B, F: 1B
- **Frame loss.** A frame that causes loss of lock is never evaluated.

## Timing
- **Reset values:** `num`=0, `seg`=0, `num_valid`=0, `locked`=0, `frame_err`=0, `pattern_err`=0. State is SEARCH and all counters are 0.
- **Reset mid-frame:** outputs return to their reset values on the next edge, and lock must be fully re-acquired.
- **Output latency:**
  - `num`, `seg`, `num_valid` and `pattern_err` update on the edge that samples the vs fall, so they are visible in the next cycle.
  - `locked` rises on that same edge.
  - `frame_err` and the fall of `locked` happen on the edge that samples the offending hs or vs fall.
- **Mutual exclusion:** `num_valid` and `pattern_err` are never high in the same cycle.
- **Simultaneous events:** an hs fall coinciding with a vs fall is the normal case.

## Configuration
- `VGA_RX_STABLE_EN` defined: a decoded value updates `num` and pulses `num_valid` only when two consecutive evaluated frames decode to the same legal code.
  - A pattern error, or loss of lock, clears the pending candidate.
  - `pattern_err` behaviour is unchanged.
- `VGA_RX_STABLE_EN` undefined: every legal evaluated frame updates `num` and pulses `num_valid`.

## Test plan
The bench timing model uses 1344x806 frames, `hs` low for cycles 0..135 of each line, and `vs` low for lines 0..5. All expectations assume `VGA_RX_STABLE_EN` is undefined unless stated otherwise.
- **Lock and first decode:** release reset, then stream digit 5 starting at a frame boundary → `locked` rises after the 3rd vs fall; `num_valid` pulses with `num`=5 and `seg`=6B after the 4th.
- **Digit change:** switch the digit from 5 to A between frames → the next evaluation gives `num`=A and `seg`=3F, with exactly one `num_valid` pulse per frame.
- **Short line:** one 1343-cycle line while locked → `frame_err` pulses and `locked` falls; there is no `num_valid` for that frame; `locked` rises again 3 vs falls later.
- **Illegal colour:** pixel (800,100) coloured 2/4/8 for one frame → `pattern_err` pulses and `num` is held.
- **Unknown pattern:** all segments dark → `pattern_err` pulses and `seg`=00.
- **Reset mid-frame, then `VGA_RX_STABLE_EN` run:**
  - Assert `rstn` low at line 400 → all outputs are 0 on the next cycle.
  - With `VGA_RX_STABLE_EN` defined, the first `num_valid` comes after the 5th vs fall.

Source files
------------

// File: rtl/vga_digit_rx.sv
// Locks to a VGA raster, then decodes the displayed seven-segment glyph once per frame.
// Optional build macro VGA_RX_STABLE_EN: publish a digit only after two matching frames.
module vga_digit_rx #(
    parameter int unsigned H_TOTAL     = 1344,
    parameter int unsigned V_TOTAL     = 806,
    parameter int unsigned LOCK_FRAMES = 2,
    // Divides the segment sample coordinates; 1 gives the nominal 1024x768 glyph.
    parameter int unsigned SEG_DIV     = 1
) (
    input  logic       clk_vga,
    input  logic       rstn,
    input  logic       hs,
    input  logic       vs,
    input  logic [3:0] r,
    input  logic [3:0] g,
    input  logic [3:0] b,
    output logic [3:0] num,
    output logic       num_valid,
    output logic       locked,
    output logic [6:0] seg,
    output logic       frame_err,
    output logic       pattern_err
);

    localparam logic [10:0] HLast = 11'(H_TOTAL - 1);
    localparam logic [10:0] VLast = 11'(V_TOTAL - 1);
    localparam logic [2:0]  LockN = 3'(LOCK_FRAMES);

    localparam logic [6:0][10:0] SegX = {
        11'(800 / SEG_DIV), 11'(950 / SEG_DIV), 11'(650 / SEG_DIV), 11'(800 / SEG_DIV),
        11'(950 / SEG_DIV), 11'(650 / SEG_DIV), 11'(800 / SEG_DIV)};
    localparam logic [6:0][10:0] SegY = {
        11'(700 / SEG_DIV), 11'(550 / SEG_DIV), 11'(550 / SEG_DIV), 11'(400 / SEG_DIV),
        11'(250 / SEG_DIV), 11'(250 / SEG_DIV), 11'(100 / SEG_DIV)};

    typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

    state_e      state_q, state_d;
    logic [2:0]  good_cnt_q, good_cnt_d;
    logic        hs_prev_q, vs_prev_q;
    logic [10:0] h_pos_q, h_pos_d, v_pos_q, v_pos_d;
    logic        hs_seen_q, hs_seen_d;
    logic [6:0]  shadow_q, shadow_d;
    logic        pix_bad_q, pix_bad_d;
    logic [3:0]  num_q, num_d;
    logic [6:0]  seg_q, seg_d;
    logic        num_valid_q, num_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        pattern_err_q, pattern_err_d;
`ifdef VGA_RX_STABLE_EN
    logic [3:0]  cand_q, cand_d;
    logic        cand_vld_q, cand_vld_d;
`endif

    logic       hs_fall, vs_fall, line_bad, frame_good, sync_bad;
    logic       lit, dark, eval, dec_ok;
    logic [3:0] dec_val;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h77:   return {1'b1, 4'h0};
            7'h24:   return {1'b1, 4'h1};
            7'h5D:   return {1'b1, 4'h2};
            7'h6D:   return {1'b1, 4'h3};
            7'h2E:   return {1'b1, 4'h4};
            7'h6B:   return {1'b1, 4'h5};
            7'h7B:   return {1'b1, 4'h6};
            7'h25:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h3F:   return {1'b1, 4'hA};
            7'h7A:   return {1'b1, 4'hB};
            7'h53:   return {1'b1, 4'hC};
            7'h7C:   return {1'b1, 4'hD};
            7'h5B:   return {1'b1, 4'hE};
            7'h1B:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    always_comb begin
        hs_fall    = hs_prev_q & ~hs;
        vs_fall    = vs_prev_q & ~vs;
        line_bad   = hs_fall & hs_seen_q & (h_pos_q != HLast);
        frame_good = vs_fall & hs_fall & ~line_bad & (v_pos_q == VLast);
        sync_bad   = line_bad | (vs_fall & ~frame_good);
        lit        = (r == 4'hF) && (g == 4'h9) && (b == 4'hC);
        dark       = ({r, g, b} == 12'h000);
        {dec_ok, dec_val} = decode(shadow_q);

        h_pos_d = hs_fall ? 11'd0 : ((h_pos_q == 11'h7FF) ? h_pos_q : h_pos_q + 11'd1);
        v_pos_d = v_pos_q;
        if (vs_fall) begin
            v_pos_d = 11'd0;
        end else if (hs_fall && v_pos_q != 11'h7FF) begin
            v_pos_d = v_pos_q + 11'd1;
        end

        shadow_d  = shadow_q;
        pix_bad_d = pix_bad_q;
        for (int i = 0; i < 7; i++) begin
            if (h_pos_q == SegX[i] && v_pos_q == SegY[i]) begin
                shadow_d[i] = lit;
                if (!lit && !dark) pix_bad_d = 1'b1;
            end
        end
        if (vs_fall) begin
            shadow_d  = 7'h00;
            pix_bad_d = 1'b0;
        end

        // LOCKED is only entered at a vs fall, so a vs fall seen in LOCKED closes a fully locked frame.
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        eval        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (vs_fall) begin
                    state_d    = StCheck;
                    good_cnt_d = 3'd0;
                end
            end
            StCheck: begin
                if (sync_bad) begin
                    state_d = StSearch;
                end else if (vs_fall) begin
                    good_cnt_d = good_cnt_q + 3'd1;
                    if (good_cnt_q + 3'd1 == LockN) state_d = StLocked;
                end
            end
            StLocked: begin
                if (sync_bad) begin
                    state_d     = StSearch;
                    frame_err_d = 1'b1;
                end else if (vs_fall) begin
                    eval = 1'b1;
                end
            end
            default: state_d = StSearch;
        endcase
        hs_seen_d = (state_d == StSearch && state_q != StSearch) ? 1'b0 : (hs_seen_q | hs_fall);

        seg_d         = seg_q;
        num_d         = num_q;
        num_valid_d   = 1'b0;
        pattern_err_d = 1'b0;
`ifdef VGA_RX_STABLE_EN
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q & (state_d != StSearch);
`endif
        if (eval) begin
            seg_d = shadow_q;
            if (pix_bad_q || !dec_ok) begin
                pattern_err_d = 1'b1;
`ifdef VGA_RX_STABLE_EN
                cand_vld_d = 1'b0;
`endif
            end else begin
`ifdef VGA_RX_STABLE_EN
                if (cand_vld_q && cand_q == dec_val) begin
                    num_d       = dec_val;
                    num_valid_d = 1'b1;
                end
                cand_d     = dec_val;
                cand_vld_d = 1'b1;
`else
                num_d       = dec_val;
                num_valid_d = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (!rstn) begin
            state_q       <= StSearch;
            good_cnt_q    <= 3'd0;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            h_pos_q       <= 11'd0;
            v_pos_q       <= 11'd0;
            hs_seen_q     <= 1'b0;
            shadow_q      <= 7'h00;
            pix_bad_q     <= 1'b0;
            num_q         <= 4'h0;
            seg_q         <= 7'h00;
            num_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            pattern_err_q <= 1'b0;
`ifdef VGA_RX_STABLE_EN
            cand_q        <= 4'h0;
            cand_vld_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            hs_prev_q     <= hs;
            vs_prev_q     <= vs;
            h_pos_q       <= h_pos_d;
            v_pos_q       <= v_pos_d;
            hs_seen_q     <= hs_seen_d;
            shadow_q      <= shadow_d;
            pix_bad_q     <= pix_bad_d;
            num_q         <= num_d;
            seg_q         <= seg_d;
            num_valid_q   <= num_valid_d;
            frame_err_q   <= frame_err_d;
            pattern_err_q <= pattern_err_d;
`ifdef VGA_RX_STABLE_EN
            cand_q        <= cand_d;
            cand_vld_q    <= cand_vld_d;
`endif
        end
    end

    assign num         = num_q;
    assign seg         = seg_q;
    assign num_valid   = num_valid_q;
    assign frame_err   = frame_err_q;
    assign pattern_err = pattern_err_q;
    assign locked      = (state_q == StLocked);

endmodule

// File: tb/tb_vga_digit_rx.sv
// Directed bench for vga_digit_rx on a raster scaled down by 50 (27x17 frames, glyph points /50)
// so that a few dozen frames stay short; sync proportions match the nominal 1344x806 timing.
module tb_vga_digit_rx;

    localparam int unsigned HT    = 27;
    localparam int unsigned VT    = 17;
    localparam int unsigned Div   = 50;
    localparam int unsigned HsLow = 3;
    localparam int unsigned VsLow = 2;
`ifdef VGA_RX_STABLE_EN
    localparam int FirstValid = 5;
`else
    localparam int FirstValid = 4;
`endif
    localparam logic [6:0] P5 = 7'h6B;
    localparam logic [6:0] PA = 7'h3F;

    logic       clk_vga = 1'b0;
    logic       rstn, hs, vs;
    logic [3:0] r, g, b;
    logic [3:0] num;
    logic       num_valid, locked, frame_err, pattern_err;
    logic [6:0] seg;

    int total = 0;
    int bad   = 0;
    int nv_cnt, pe_cnt, fe_cnt;
    int both_cnt = 0;
    logic [3:0] nv_num;
    int spec_x [7] = '{800, 650, 950, 800, 650, 950, 800};
    int spec_y [7] = '{100, 250, 250, 400, 550, 550, 700};

    always #5 clk_vga = ~clk_vga;

    vga_digit_rx #(
        .H_TOTAL    (HT),
        .V_TOTAL    (VT),
        .LOCK_FRAMES(2),
        .SEG_DIV    (Div)
    ) dut (
        .clk_vga    (clk_vga),
        .rstn       (rstn),
        .hs         (hs),
        .vs         (vs),
        .r          (r),
        .g          (g),
        .b          (b),
        .num        (num),
        .num_valid  (num_valid),
        .locked     (locked),
        .seg        (seg),
        .frame_err  (frame_err),
        .pattern_err(pattern_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_vga);
        #1;
        if (num_valid) begin
            nv_cnt++;
            nv_num = num;
        end
        if (pattern_err) pe_cnt++;
        if (frame_err) fe_cnt++;
        if (num_valid && pattern_err) both_cnt++;
    endtask

    // One frame; raster pixel x of line y is driven in line cycle x+1.
    task automatic run_frame(input logic [6:0] pat, input bit bad_pix, input int short_line,
                             input int rst_line);
        int len;
        nv_cnt = 0;
        pe_cnt = 0;
        fe_cnt = 0;
        for (int l = 0; l < int'(VT); l++) begin
            len = (l == short_line) ? int'(HT) - 1 : int'(HT);
            for (int c = 0; c < len; c++) begin
                hs = (c < int'(HsLow)) ? 1'b0 : 1'b1;
                vs = (l < int'(VsLow)) ? 1'b0 : 1'b1;
                {r, g, b} = 12'h000;
                for (int i = 0; i < 7; i++) begin
                    if (c - 1 == spec_x[i] / int'(Div) && l == spec_y[i] / int'(Div)) begin
                        if (bad_pix && i == 0) {r, g, b} = 12'h248;
                        else if (pat[i]) {r, g, b} = 12'hF9C;
                    end
                end
                if (l == rst_line && c == 10) begin
                    chk("locked_before_reset", locked, 1);
                    rstn = 1'b0;
                    step();
                    chk("rst_mid_num", num, 0);
                    chk("rst_mid_seg", seg, 0);
                    chk("rst_mid_num_valid", num_valid, 0);
                    chk("rst_mid_locked", locked, 0);
                    chk("rst_mid_frame_err", frame_err, 0);
                    chk("rst_mid_pattern_err", pattern_err, 0);
                    rstn = 1'b1;
                end else begin
                    step();
                end
            end
        end
    endtask

    initial begin
        int first;
        logic [3:0] first_num;
        rstn = 1'b0;
        hs = 1'b1;
        vs = 1'b1;
        {r, g, b} = 12'h000;
        nv_num = 4'h0;
        repeat (3) step();
        chk("reset_num", num, 0);
        chk("reset_seg", seg, 0);
        chk("reset_num_valid", num_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_pattern_err", pattern_err, 0);
        rstn = 1'b1;
        step();

        run_frame(P5, 0, -1, -1);
        chk("lock_after_vs1", locked, 0);
        run_frame(P5, 0, -1, -1);
        chk("lock_after_vs2", locked, 0);
        run_frame(P5, 0, -1, -1);
        chk("lock_after_vs3", locked, 1);
        chk("no_valid_vs3", nv_cnt, 0);

        run_frame(PA, 0, -1, -1);
        chk("decode5_pulses", nv_cnt, 1);
        chk("decode5_num", nv_num, 4'h5);
        chk("decode5_seg", seg, 7'h6B);

        run_frame(PA, 0, -1, -1);
        chk("decodeA_pulses", nv_cnt, 1);
        chk("decodeA_num", nv_num, 4'hA);
        chk("decodeA_seg", seg, 7'h3F);

        run_frame(PA, 0, 5, -1);
        chk("short_prev_valid", nv_cnt, 1);
        chk("short_frame_err", fe_cnt, 1);
        chk("short_locked", locked, 0);
        run_frame(PA, 0, -1, -1);
        chk("short_no_valid", nv_cnt, 0);
        chk("relock_vs1", locked, 0);
        run_frame(PA, 0, -1, -1);
        chk("relock_vs2", locked, 0);
        run_frame(PA, 1, -1, -1);
        chk("relock_vs3", locked, 1);

        run_frame(7'h00, 0, -1, -1);
        chk("badpix_pattern_err", pe_cnt, 1);
        chk("badpix_no_valid", nv_cnt, 0);
        chk("badpix_num_held", num, 4'hA);

        run_frame(P5, 0, -1, -1);
        chk("dark_pattern_err", pe_cnt, 1);
        chk("dark_no_valid", nv_cnt, 0);
        chk("dark_seg", seg, 7'h00);
        chk("dark_num_held", num, 4'hA);

        run_frame(P5, 0, -1, 8);
        chk("pre_reset_valid", nv_cnt, 1);
        chk("pre_reset_num", nv_num, 4'h5);

        first = 0;
        first_num = 4'h0;
        for (int k = 1; k <= 6; k++) begin
            run_frame(P5, 0, -1, -1);
            if (nv_cnt > 0 && first == 0) begin
                first = k;
                first_num = nv_num;
            end
        end
        chk("after_reset_first_valid_vs", first, FirstValid);
        chk("after_reset_num", first_num, 4'h5);
        chk("valid_err_exclusive", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
